// File: rtl/gg_dma_rdctl.sv
// DMA read controller: issues 24-beat AXI4 AR bursts over a macroblock-aligned DRAM ring,
// optionally paced against a producer write pointer, with a bounded number of bursts in flight.
module gg_dma_rdctl #(
  parameter int ADDR_W   = 40,
  parameter int MB_BYTES = 384,
  parameter int MAX_OUT  = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              go,
  input  logic              cont,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W-1:0] limit_addr,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [15:0]       mb_count,
  output logic              m_arvalid,
  input  logic              m_arready,
  output logic [ADDR_W-1:0] m_araddr,
  output logic [7:0]        m_arlen,
  output logic [2:0]        m_arsize,
  output logic [3:0]        m_arcache,
  input  logic              rlast_done,
  output logic [ADDR_W-1:0] rd_addr,
  output logic              busy,
  output logic              wait_wr,
  output logic              done
);

  localparam int OUT_W = ($clog2(MAX_OUT + 1) < 3) ? 3 : $clog2(MAX_OUT + 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    WAIT_WR = 2'd2,
    DRAIN   = 2'd3
  } state_t;

  state_t             state_r;
  logic               go_q_r;
  logic               cont_r;
  logic               limited_r;
  logic [15:0]        mb_left_r;
  logic [OUT_W-1:0]   outstanding_r;
  logic               hs_s;
  logic               stop_s;
  logic               credit_s;
  logic [ADDR_W-1:0]  inc_addr_s;
  logic [ADDR_W-1:0]  next_addr_s;

  assign m_arlen   = 8'd23;
  assign m_arsize  = 3'b100;
  assign m_arcache = 4'b0011;

  // Handshake, ring wrap (tested on the post-increment address) and stop/credit conditions.
  always_comb begin
    hs_s       = m_arvalid & m_arready;
    inc_addr_s = rd_addr + ADDR_W'(MB_BYTES);
    if (inc_addr_s >= limit_addr) begin
      next_addr_s = base_addr;
    end else begin
      next_addr_s = inc_addr_s;
    end
    stop_s   = ~go | (limited_r & (mb_left_r == 16'd0));
    credit_s = (outstanding_r < OUT_W'(MAX_OUT));
  end

  // Bursts in flight: an AR handshake and an rlast in the same cycle cancel out.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      outstanding_r <= {OUT_W{1'b0}};
    end else if (hs_s && !rlast_done) begin
      outstanding_r <= outstanding_r + OUT_W'(1);
    end else if (!hs_s && rlast_done && (outstanding_r != {OUT_W{1'b0}})) begin
      outstanding_r <= outstanding_r - OUT_W'(1);
    end
  end

  // Control FSM with registered AR channel and status outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r   <= IDLE;
      go_q_r    <= 1'b0;
      cont_r    <= 1'b0;
      limited_r <= 1'b0;
      mb_left_r <= 16'd0;
      rd_addr   <= {ADDR_W{1'b0}};
      m_arvalid <= 1'b0;
      m_araddr  <= {ADDR_W{1'b0}};
      busy      <= 1'b0;
      wait_wr   <= 1'b0;
      done      <= 1'b0;
    end else begin
      go_q_r <= go;
      done   <= 1'b0;
      if (hs_s) begin
        m_arvalid <= 1'b0;
        rd_addr   <= next_addr_s;
        if (limited_r && (mb_left_r != 16'd0)) begin
          mb_left_r <= mb_left_r - 16'd1;
        end
      end
      case (state_r)
        IDLE: begin
          if (go && !go_q_r) begin
            rd_addr   <= start_addr;
            mb_left_r <= mb_count;
            limited_r <= (mb_count != 16'd0);
            cont_r    <= cont;
            state_r   <= ISSUE;
            busy      <= 1'b1;
          end
        end
        ISSUE: begin
          // A pending AR is held untouched until accepted.
          if (!m_arvalid) begin
            if (stop_s) begin
              state_r <= DRAIN;
            end else if (cont_r && (rd_addr == wr_addr)) begin
              state_r <= WAIT_WR;
              wait_wr <= 1'b1;
            end else if (credit_s) begin
              m_arvalid <= 1'b1;
              m_araddr  <= rd_addr;
            end
          end
        end
        WAIT_WR: begin
          if (stop_s) begin
            state_r <= DRAIN;
            wait_wr <= 1'b0;
          end else if (rd_addr != wr_addr) begin
            state_r <= ISSUE;
            wait_wr <= 1'b0;
          end
        end
        DRAIN: begin
          if (outstanding_r == {OUT_W{1'b0}}) begin
            state_r <= IDLE;
            busy    <= 1'b0;
            done    <= 1'b1;
          end
        end
        default: begin
          state_r   <= IDLE;
          m_arvalid <= 1'b0;
          busy      <= 1'b0;
          wait_wr   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_gg_dma_rdctl.sv
// Directed bench for gg_dma_rdctl: ring wrap, write-pointer pacing, credit limit,
// AR stall with go drop, and asynchronous reset during drain.
module tb_gg_dma_rdctl;

  localparam int ADDR_W = 40;

  logic              clk = 1'b0;
  logic              reset_n;
  logic              go;
  logic              cont;
  logic [ADDR_W-1:0] base_addr;
  logic [ADDR_W-1:0] limit_addr;
  logic [ADDR_W-1:0] start_addr;
  logic [ADDR_W-1:0] wr_addr;
  logic [15:0]       mb_count;
  logic              m_arvalid;
  logic              m_arready;
  logic [ADDR_W-1:0] m_araddr;
  logic [7:0]        m_arlen;
  logic [2:0]        m_arsize;
  logic [3:0]        m_arcache;
  logic              rlast_done;
  logic [ADDR_W-1:0] rd_addr;
  logic              busy;
  logic              wait_wr;
  logic              done;

  int total = 0;
  int bad   = 0;
  int done_cnt = 0;
  logic [ADDR_W-1:0] ar_q[$];
  int n0;
  int d0;

  gg_dma_rdctl #(.ADDR_W(ADDR_W), .MB_BYTES(384), .MAX_OUT(4)) dut (
    .clk(clk), .reset_n(reset_n), .go(go), .cont(cont),
    .base_addr(base_addr), .limit_addr(limit_addr), .start_addr(start_addr),
    .wr_addr(wr_addr), .mb_count(mb_count),
    .m_arvalid(m_arvalid), .m_arready(m_arready), .m_araddr(m_araddr),
    .m_arlen(m_arlen), .m_arsize(m_arsize), .m_arcache(m_arcache),
    .rlast_done(rlast_done), .rd_addr(rd_addr), .busy(busy),
    .wait_wr(wait_wr), .done(done)
  );

  always #5 clk = ~clk;

  // Record every accepted AR address and every done pulse.
  always @(posedge clk) begin
    if (m_arvalid && m_arready) ar_q.push_back(m_araddr);
    if (done) done_cnt <= done_cnt + 1;
  end

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic pulse_rlast();
    rlast_done = 1'b1;
    tick(1);
    rlast_done = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      tick(1);
      if (done) seen = 1'b1;
    end
    chk(tag, {63'd0, seen}, 64'd1);
    tick(1);
    chk({tag, "_pulse1"}, {63'd0, done}, 64'd0);
    chk({tag, "_idle"}, {63'd0, busy}, 64'd0);
  endtask

  initial begin
    reset_n = 1'b0; go = 1'b0; cont = 1'b0; m_arready = 1'b0; rlast_done = 1'b0;
    base_addr = 40'h0; limit_addr = 40'h0; start_addr = 40'h0; wr_addr = 40'h0;
    mb_count = 16'd0;
    tick(2);
    chk("rst_arvalid", {63'd0, m_arvalid}, 64'd0);
    chk("rst_araddr", {24'd0, m_araddr}, 64'd0);
    chk("rst_busy", {63'd0, busy}, 64'd0);
    chk("rst_done", {63'd0, done}, 64'd0);
    chk("arlen", {56'd0, m_arlen}, 64'd23);
    chk("arsize", {61'd0, m_arsize}, 64'd4);
    chk("arcache", {60'd0, m_arcache}, 64'd3);
    reset_n = 1'b1;
    tick(1);

    // Recon wrap: 0x1300 -> wrap to 0x1000 -> 0x1180
    base_addr = 40'h1000; limit_addr = 40'h1480; start_addr = 40'h1300;
    cont = 1'b0; mb_count = 16'd3; m_arready = 1'b1;
    go = 1'b1;
    tick(1);
    chk("t1_busy", {63'd0, busy}, 64'd1);
    chk("t1_av_early", {63'd0, m_arvalid}, 64'd0);
    tick(1);
    chk("t1_lat_av", {63'd0, m_arvalid}, 64'd1);
    chk("t1_lat_addr", {24'd0, m_araddr}, 64'h1300);
    tick(8);
    chk("t1_ar_n", ar_q.size(), 64'd3);
    chk("t1_a0", {24'd0, ar_q[0]}, 64'h1300);
    chk("t1_a1", {24'd0, ar_q[1]}, 64'h1000);
    chk("t1_a2", {24'd0, ar_q[2]}, 64'h1180);
    pulse_rlast(); pulse_rlast();
    tick(2);
    chk("t1_nodone", done_cnt, 64'd0);
    chk("t1_drain_busy", {63'd0, busy}, 64'd1);
    pulse_rlast();
    wait_done("t1_done");
    tick(4);
    chk("t1_go_held", {63'd0, busy}, 64'd0);
    chk("t1_go_held_ar", ar_q.size(), 64'd3);

    // Pacing against wr_addr
    go = 1'b0;
    tick(1);
    base_addr = 40'h2000; limit_addr = 40'h3000; start_addr = 40'h2000;
    wr_addr = 40'h2000; cont = 1'b1; mb_count = 16'd0;
    n0 = ar_q.size();
    go = 1'b1;
    tick(3);
    chk("t2_wait", {63'd0, wait_wr}, 64'd1);
    chk("t2_no_av", {63'd0, m_arvalid}, 64'd0);
    chk("t2_no_ar", ar_q.size(), n0);
    wr_addr = 40'h2180;
    tick(6);
    chk("t2_one_ar", ar_q.size(), n0 + 1);
    chk("t2_addr", {24'd0, ar_q[n0]}, 64'h2000);
    chk("t2_rewait", {63'd0, wait_wr}, 64'd1);
    chk("t2_rd_addr", {24'd0, rd_addr}, 64'h2180);
    go = 1'b0;
    tick(2);
    chk("t2_drain_wait", {63'd0, wait_wr}, 64'd0);
    pulse_rlast();
    wait_done("t2_done");

    // Credit limit of four outstanding bursts
    base_addr = 40'h1000; limit_addr = 40'h1480; start_addr = 40'h1000;
    cont = 1'b0; mb_count = 16'd0; m_arready = 1'b1;
    n0 = ar_q.size();
    go = 1'b1;
    tick(20);
    chk("t3_four", ar_q.size(), n0 + 4);
    chk("t3_stall_av", {63'd0, m_arvalid}, 64'd0);
    chk("t3_a3", {24'd0, ar_q[n0 + 3]}, 64'h1000);
    pulse_rlast();
    tick(10);
    chk("t3_five", ar_q.size(), n0 + 5);
    chk("t3_a4", {24'd0, ar_q[n0 + 4]}, 64'h1180);
    go = 1'b0;
    tick(2);
    pulse_rlast(); pulse_rlast(); pulse_rlast();
    tick(2);
    chk("t3_nodone", {63'd0, busy}, 64'd1);
    pulse_rlast();
    wait_done("t3_done");

    // AR stall with go dropped mid-request
    m_arready = 1'b0; start_addr = 40'h1180;
    n0 = ar_q.size();
    d0 = done_cnt;
    go = 1'b1;
    tick(2);
    chk("t4_av", {63'd0, m_arvalid}, 64'd1);
    go = 1'b0; wr_addr = 40'h5555;
    tick(3);
    chk("t4_hold_av", {63'd0, m_arvalid}, 64'd1);
    chk("t4_hold_addr", {24'd0, m_araddr}, 64'h1180);
    m_arready = 1'b1;
    tick(1);
    chk("t4_av_drop", {63'd0, m_arvalid}, 64'd0);
    chk("t4_hs", ar_q.size(), n0 + 1);
    tick(3);
    chk("t4_no_more_ar", ar_q.size(), n0 + 1);
    chk("t4_nodone", done_cnt, d0);
    chk("t4_busy", {63'd0, busy}, 64'd1);
    pulse_rlast();
    wait_done("t4_done");

    // Async reset while draining with two bursts outstanding
    start_addr = 40'h1000; mb_count = 16'd2; m_arready = 1'b1;
    n0 = ar_q.size();
    go = 1'b1;
    tick(10);
    chk("t5_two", ar_q.size(), n0 + 2);
    chk("t5_busy", {63'd0, busy}, 64'd1);
    d0 = done_cnt;
    reset_n = 1'b0;
    #1;
    chk("t5_rst_av", {63'd0, m_arvalid}, 64'd0);
    chk("t5_rst_addr", {24'd0, m_araddr}, 64'd0);
    chk("t5_rst_rd", {24'd0, rd_addr}, 64'd0);
    chk("t5_rst_busy", {63'd0, busy}, 64'd0);
    chk("t5_rst_wait", {63'd0, wait_wr}, 64'd0);
    chk("t5_rst_done", {63'd0, done}, 64'd0);
    go = 1'b0;
    tick(2);
    reset_n = 1'b1;
    pulse_rlast(); pulse_rlast();
    tick(4);
    chk("t5_no_done", done_cnt, d0);
    chk("t5_no_ar", ar_q.size(), n0 + 2);
    chk("t5_idle", {63'd0, busy}, 64'd0);
    go = 1'b1;
    tick(2);
    chk("t5_restart_av", {63'd0, m_arvalid}, 64'd1);
    chk("t5_restart_addr", {24'd0, m_araddr}, 64'h1000);
    go = 1'b0;
    tick(4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
